match_event_logger: RTL

Downstream consumer of the serial `101` Mealy sequence detector. It takes the detector's single-bit match output and timestamps every match against a free-running cycle counter. Each timestamp is buffered in a small first-word-fall-through FIFO, and a valid/ready port lets a host or bus agent drain it. The block also keeps a saturating match count and a sticky lost-event flag.

---
 rtl/match_event_logger.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/match_event_logger.sv
// Timestamps each sampled match against a free-running counter and queues it in a FWFT FIFO.
// Latency: 1 cycle from match to evt_valid/evt_ts; a pop takes effect at the accepting edge.
// Backpressure: evt_valid/evt_ready; a push into a full FIFO with no pop is dropped and flagged.

module match_event_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  logic [W-1:0]             push_dat_i,
    input  logic                     pop_i,
    output logic                     vld_o,
    output logic [W-1:0]             head_dat_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     drop_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;

    logic full;
    logic do_pop;
    logic do_push;

    assign full    = (level_q == LW'(DEPTH));
    assign vld_o   = (level_q != '0);
    assign do_pop  = vld_o && pop_i && !clr_i;
    // A simultaneous pop frees the slot, so a push into a full FIFO is only lost without one.
    assign do_push = push_i && !clr_i && (!full || do_pop);
    assign drop_o  = push_i && !clr_i && full && !do_pop;

    assign head_dat_o = mem_q[rd_ptr_q];
    assign level_o    = level_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

module match_event_logger #(
    parameter int TS_W  = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     match,
    input  logic                     clear,
    input  logic                     evt_ready,
    output logic                     evt_valid,
    output logic [TS_W-1:0]          evt_ts,
    output logic                     evt_lost,
    output logic [CNT_W-1:0]         match_count,
    output logic [$clog2(DEPTH):0]   fifo_level
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [TS_W-1:0]  ts_q, ts_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lost_q, lost_d;
    logic             drop;

    // The pushed stamp is the counter value held before the capturing edge.
    match_event_fifo #(
        .W     (TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (clear),
        .push_i     (match),
        .push_dat_i (ts_q),
        .pop_i      (evt_ready),
        .vld_o      (evt_valid),
        .head_dat_o (evt_ts),
        .level_o    (fifo_level),
        .drop_o     (drop)
    );

    always_comb begin
        ts_d   = ts_q + TS_W'(1);
        cnt_d  = cnt_q;
        lost_d = lost_q | drop;
        if (clear) begin
            cnt_d  = '0;
            lost_d = 1'b0;
        end else if (match && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_q   <= '0;
            cnt_q  <= '0;
            lost_q <= 1'b0;
        end else begin
            ts_q   <= ts_d;
            cnt_q  <= cnt_d;
            lost_q <= lost_d;
        end
    end

    assign evt_lost    = lost_q;
    assign match_count = cnt_q;

endmodule
